// File: rtl/rom_streamer_if.sv
// Valid/ready word stream carrying ROM words to a downstream consumer.
//   data   master -> slave   DATA_WIDTH  word being presented
//   valid  master -> slave   1           data holds a word
//   ready  slave  -> master  1           consumer can take the word
// A transfer happens on every rising edge where valid && ready.
interface rom_streamer_if #(
   parameter int DATA_WIDTH = 9
);
   logic [DATA_WIDTH-1:0] data;
   logic                  valid;
   logic                  ready;

   modport master (output data, output valid, input ready);
   modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/rom_streamer.sv
// Read-side sequencer for an asynchronous ROM.
// On start it walks `count` consecutive ROM addresses from `start_addr`
// (wrapping at the top of the ROM) and presents each word on a registered
// valid/ready stream.
// Ports:
//   clk         single clock, all state on the rising edge
//   reset       synchronous, active-high
//   start       request a burst (only looked at while idle)
//   start_addr  first ROM address of the burst
//   count       number of words, 0 .. 2**ADDR_WIDTH
//   abort       cancel the current burst, drops any presented word
//   rom_addr    registered address to the ROM
//   rom_data    combinational ROM output for rom_addr
//   stream      valid/ready output stream (master side)
//   busy        high whenever a burst is in progress
//   done        one-cycle pulse after the last word of a burst is taken
module rom_streamer #(
   parameter int DATA_WIDTH = 9,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] start_addr,
   input  logic [ADDR_WIDTH:0]   count,
   input  logic                  abort,
   output logic [ADDR_WIDTH-1:0] rom_addr,
   input  logic [DATA_WIDTH-1:0] rom_data,
   rom_streamer_if.master        stream,
   output logic                  busy,
   output logic                  done
);

   typedef enum logic {
      IDLE   = 1'b0,
      STREAM = 1'b1
   } state_t;

   state_t                state_reg, state_next;
   logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
   logic [ADDR_WIDTH:0]   remaining_reg, remaining_next;
   logic [DATA_WIDTH-1:0] data_reg, data_next;
   logic                  valid_reg, valid_next;
   logic                  done_reg, done_next;

   logic                  load;
   logic                  last_taken;

   // A new word may be fetched when words remain and the output register is
   // empty or is being emptied this cycle, giving one word per cycle while
   // the consumer keeps ready high.
   assign load       = (remaining_reg != '0) && (!valid_reg || stream.ready);
   assign last_taken = (remaining_reg == '0) && valid_reg && stream.ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg     <= IDLE;
         addr_reg      <= '0;
         remaining_reg <= '0;
         data_reg      <= '0;
         valid_reg     <= 1'b0;
         done_reg      <= 1'b0;
      end else begin
         state_reg     <= state_next;
         addr_reg      <= addr_next;
         remaining_reg <= remaining_next;
         data_reg      <= data_next;
         valid_reg     <= valid_next;
         done_reg      <= done_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      addr_next      = addr_reg;
      remaining_next = remaining_reg;
      data_next      = data_reg;
      valid_next     = valid_reg;
      done_next      = 1'b0;

      if (abort) begin
         // Abort outranks everything; a word on the bus this cycle is dropped
         // even if the consumer is ready. Address and data simply hold.
         state_next     = IDLE;
         valid_next     = 1'b0;
         remaining_next = '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (start) begin
                  if (count != '0) begin
                     addr_next      = start_addr;
                     remaining_next = count;
                     state_next     = STREAM;
                  end else begin
                     // Empty burst: complete immediately, emit nothing.
                     done_next = 1'b1;
                  end
               end
            end
            STREAM: begin
               if (load) begin
                  data_next      = rom_data;
                  valid_next     = 1'b1;
                  addr_next      = addr_reg + 1'b1;   // wraps silently
                  remaining_next = remaining_reg - 1'b1;
               end else if (last_taken) begin
                  valid_next = 1'b0;
                  state_next = IDLE;
                  done_next  = 1'b1;
               end
            end
            default: state_next = IDLE;
         endcase
      end
   end

   assign rom_addr     = addr_reg;
   assign stream.data  = data_reg;
   assign stream.valid = valid_reg;
   assign busy         = (state_reg != IDLE);
   assign done         = done_reg;

endmodule

// File: tb/tb_rom_streamer.sv
module tb_rom_streamer;
   localparam int DW = 9;
   localparam int AW = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [AW-1:0] start_addr;
   logic [AW:0]   count;
   logic          abort;
   logic [AW-1:0] rom_addr;
   logic [DW-1:0] rom_data;
   logic          busy;
   logic          done;

   rom_streamer_if #(.DATA_WIDTH(DW)) stream ();

   rom_streamer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .start_addr (start_addr),
      .count      (count),
      .abort      (abort),
      .rom_addr   (rom_addr),
      .rom_data   (rom_data),
      .stream     (stream.master),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   // ROM model: ROM[i] = i*3
   assign rom_data = 9'(rom_addr) * 9'd3;

   int checks = 0;
   int errors = 0;
   logic [DW-1:0] exp_q[$];

   // monitor state
   int cyc = 0;
   int xfer_count = 0;
   int last_xfer_cyc = 0;
   int done_count = 0;
   int done_cyc = 0;
   logic          prev_stall = 1'b0;
   logic          prev_exempt = 1'b0;
   logic [DW-1:0] prev_data = '0;

   task automatic check(input string name, input int actual, input int expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, actual, expected);
      end else begin
         $display("ok   %s: %0d", name, actual);
      end
   endtask

   // Monitor: scoreboard pop on every transfer, stall-stability check.
   always @(negedge clk) begin
      cyc++;
      if (prev_stall && !prev_exempt) begin
         checks++;
         if (stream.valid !== 1'b1 || stream.data !== prev_data) begin
            errors++;
            $display("FAIL stall_hold: got valid=%0b data=%0d expected valid=1 data=%0d",
                     stream.valid, stream.data, prev_data);
         end
      end
      if (stream.valid === 1'b1 && stream.ready === 1'b1 && !abort && !reset) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL xfer_unexpected: got data=%0d expected no transfer", stream.data);
         end else begin
            logic [DW-1:0] e;
            e = exp_q.pop_front();
            if (stream.data !== e) begin
               errors++;
               $display("FAIL xfer_data: got %0d expected %0d", stream.data, e);
            end else begin
               $display("xfer data=%0d at cycle %0d", stream.data, cyc);
            end
         end
         xfer_count++;
         last_xfer_cyc = cyc;
      end
      if (done === 1'b1) begin
         done_count++;
         done_cyc = cyc;
      end
      prev_stall  = (stream.valid === 1'b1) && (stream.ready !== 1'b1);
      prev_exempt = abort || reset;
      prev_data   = stream.data;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic [AW-1:0] a, input logic [AW:0] n);
      start_addr = a;
      count      = n;
      start      = 1'b1;
      step();
      start      = 1'b0;
   endtask

   task automatic push_burst(input int a, input int n);
      for (int i = 0; i < n; i++) exp_q.push_back(9'(((a + i) % 16) * 3));
   endtask

   // waits for done with a cycle bound; ready follows an optional 1,0,0 pattern
   task automatic wait_done(input string name, input bit toggle);
      int k;
      bit seen;
      seen = 1'b0;
      for (k = 0; k < 60 && !seen; k++) begin
         if (toggle) stream.ready = (k % 3 == 0);
         if (done) seen = 1'b1;
         else step();
      end
      stream.ready = 1'b1;
      if (!seen) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout: got no done expected done within 60 cycles", name);
      end
   endtask

   initial begin
      int x0, d0;
      reset = 1'b1; start = 1'b0; abort = 1'b0;
      start_addr = '0; count = '0; stream.ready = 1'b1;
      repeat (3) step();
      reset = 1'b0;
      check("reset_valid", int'(stream.valid), 0);
      check("reset_busy", int'(busy), 0);
      check("reset_done", int'(done), 0);
      check("reset_addr", int'(rom_addr), 0);
      check("reset_data", int'(stream.data), 0);

      // Basic burst: 6,9,12,15
      x0 = xfer_count; d0 = done_count;
      push_burst(2, 4);
      do_start(4'd2, 5'd4);
      check("lat_busy_t1", int'(busy), 1);
      check("lat_valid_t1", int'(stream.valid), 0);
      step();
      check("lat_valid_t2", int'(stream.valid), 1);
      check("lat_data_t2", int'(stream.data), 6);
      wait_done("basic", 1'b0);
      step();
      check("basic_done_pulse_len", int'(done), 0);
      check("basic_xfers", xfer_count - x0, 4);
      check("basic_done_cycle", done_cyc - last_xfer_cyc, 1);
      check("basic_busy_after", int'(busy), 0);

      // Wrap-around: 42,45,0,3
      x0 = xfer_count;
      push_burst(14, 4);
      do_start(4'd14, 5'd4);
      wait_done("wrap", 1'b0);
      step();
      check("wrap_xfers", xfer_count - x0, 4);

      // Full ROM
      x0 = xfer_count;
      push_burst(5, 16);
      do_start(4'd5, 5'd16);
      wait_done("full", 1'b0);
      step();
      check("full_xfers", xfer_count - x0, 16);

      // count = 0
      x0 = xfer_count;
      do_start(4'd3, 5'd0);
      check("zero_done_t1", int'(done), 1);
      check("zero_busy_t1", int'(busy), 0);
      step();
      check("zero_done_t2", int'(done), 0);
      check("zero_valid", int'(stream.valid), 0);
      step();
      check("zero_xfers", xfer_count - x0, 0);

      // Stalls with ready 1,0,0 pattern: 21,24,27
      x0 = xfer_count;
      push_burst(7, 3);
      do_start(4'd7, 5'd3);
      wait_done("stall", 1'b1);
      step();
      check("stall_xfers", xfer_count - x0, 3);

      // Abort on the cycle of the 2nd transfer
      x0 = xfer_count; d0 = done_count;
      push_burst(0, 1);
      do_start(4'd0, 5'd4);
      step();            // first word valid (0), transfers at this cycle
      step();            // second word valid (3)
      check("abort_pre_valid", int'(stream.valid), 1);
      abort = 1'b1;
      start = 1'b1;      // dropped: abort wins
      step();
      abort = 1'b0;
      start = 1'b0;
      check("abort_valid", int'(stream.valid), 0);
      check("abort_busy", int'(busy), 0);
      check("abort_done", int'(done), 0);
      step();
      check("abort_busy_after", int'(busy), 0);
      check("abort_xfers", xfer_count - x0, 1);
      check("abort_no_done", done_count - d0, 0);

      // New start after abort: 15,18
      x0 = xfer_count;
      push_burst(5, 2);
      do_start(4'd5, 5'd2);
      wait_done("post_abort", 1'b0);
      step();
      check("post_abort_xfers", xfer_count - x0, 2);

      // Start while busy is ignored: 3,6,9 only
      x0 = xfer_count;
      push_burst(1, 3);
      do_start(4'd1, 5'd3);
      start_addr = 4'd10; count = 5'd5; start = 1'b1;
      step();
      start = 1'b0;
      wait_done("busy_start", 1'b0);
      repeat (3) step();
      check("busy_start_xfers", xfer_count - x0, 3);
      check("busy_start_idle", int'(busy), 0);

      // Reset mid-burst with consumer stalled
      d0 = done_count;
      stream.ready = 1'b0;
      do_start(4'd4, 5'd6);
      repeat (3) step();
      check("midrst_valid_pre", int'(stream.valid), 1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("midrst_valid", int'(stream.valid), 0);
      check("midrst_busy", int'(busy), 0);
      check("midrst_done", int'(done), 0);
      check("midrst_addr", int'(rom_addr), 0);
      check("midrst_data", int'(stream.data), 0);
      stream.ready = 1'b1;
      repeat (2) step();
      check("midrst_no_done", done_count - d0, 0);
      check("queue_empty", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish expected finish before 200000");
      $fatal(1, "timeout");
   end
endmodule
